// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// Owner encoding, default widths, perf counter width and helper.
package sp_ram_pkg;

  localparam int DEF_MEM_WIDTH  = 24;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int PERF_CNT_W     = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(
    input logic [PERF_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sp_ram_rr_arbiter_if.sv
// Per-requester access port: valid/ready request plus response strobe.
// master = requester side, slave = arbiter side.
interface sp_ram_rr_arbiter_if
  import sp_ram_pkg::*;
#(
  parameter int AW = DEF_ADDR_WIDTH,
  parameter int DW = DEF_MEM_WIDTH
);
  logic          valid;
  logic          ready;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rsp_valid;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid
  );
endinterface

// File: rtl/sp_ram_rr_grant.sv
// Two-way round-robin grant with its priority pointer.
// Pointer flips to the losing side after every grant.
module sp_ram_rr_grant (
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  output logic gnt_a,
  output logic gnt_b
);

  logic ptr_b;

  // grant decode: lone requester wins, pointer breaks ties
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (1'b1)
      (a_valid && (!b_valid || !ptr_b)): gnt_a = 1'b1;
      (b_valid && (!a_valid ||  ptr_b)): gnt_b = 1'b1;
      default: ;
    endcase
  end

  // pointer moves to the non-granted side, holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_b <= 1'b0;
    end else if (gnt_a) begin
      ptr_b <= 1'b1;
    end else if (gnt_b) begin
      ptr_b <= 1'b0;
    end
  end

endmodule

// File: rtl/sp_ram_rr_arbiter.sv
// Round-robin front end sharing one read-first single-port RAM.
// Optional perf counters: define SP_RAM_ARB_PERF_CNT_EN.
module sp_ram_rr_arbiter
  import sp_ram_pkg::*;
#(
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sp_ram_rr_arbiter_if.slave    a,
  sp_ram_rr_arbiter_if.slave    b,
  output logic [MEM_WIDTH-1:0]  rsp_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0]  ram_din,
  input  logic [MEM_WIDTH-1:0]  ram_dout
`ifdef SP_RAM_ARB_PERF_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [PERF_CNT_W-1:0] a_grant_cnt,
  output logic [PERF_CNT_W-1:0] b_grant_cnt,
  output logic [PERF_CNT_W-1:0] conflict_cnt
`endif
);

  logic   gnt_a;
  logic   gnt_b;
  logic   we_sel;
  owner_e own_d;
  owner_e own_q;

  sp_ram_rr_grant u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a.valid),
    .b_valid (b.valid),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  assign a.ready = gnt_a;
  assign b.ready = gnt_b;

  // steer the granted request onto the RAM, zeros when idle
  always_comb begin
    we_sel   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    own_d    = OWN_NONE;
    unique case (1'b1)
      gnt_a: begin
        we_sel   = a.we;
        ram_addr = a.addr;
        ram_din  = a.wdata;
        own_d    = OWN_A;
      end
      gnt_b: begin
        we_sel   = b.we;
        ram_addr = b.addr;
        ram_din  = b.wdata;
        own_d    = OWN_B;
      end
      default: ;
    endcase
  end

  // reset must never corrupt memory contents
  assign ram_we = we_sel & rst_n;

  // remember who owns the word the RAM returns next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q <= OWN_NONE;
    end else begin
      own_q <= own_d;
    end
  end

  assign a.rsp_valid = rst_n && (own_q == OWN_A);
  assign b.rsp_valid = rst_n && (own_q == OWN_B);
  assign rsp_rdata   = ram_dout;

`ifdef SP_RAM_ARB_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] a_cnt_q;
  logic [PERF_CNT_W-1:0] b_cnt_q;
  logic [PERF_CNT_W-1:0] c_cnt_q;

  // saturating grant and contention counters, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      c_cnt_q <= '0;
    end else if (cnt_clr) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      c_cnt_q <= '0;
    end else begin
      if (gnt_a) a_cnt_q <= sat_inc(a_cnt_q);
      if (gnt_b) b_cnt_q <= sat_inc(b_cnt_q);
      if (a.valid && b.valid) c_cnt_q <= sat_inc(c_cnt_q);
    end
  end

  assign a_grant_cnt  = a_cnt_q;
  assign b_grant_cnt  = b_cnt_q;
  assign conflict_cnt = c_cnt_q;
`endif

endmodule

// File: tb/tb_sp_ram_rr_arbiter.sv
// Directed bench for sp_ram_rr_arbiter with a read-first RAM model.
// Perf counter steps run only with SP_RAM_ARB_PERF_CNT_EN.
module tb_sp_ram_rr_arbiter;
  import sp_ram_pkg::*;

  localparam int DW = 24;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rsp_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
`ifdef SP_RAM_ARB_PERF_CNT_EN
  logic          cnt_clr;
  logic [15:0]   a_grant_cnt;
  logic [15:0]   b_grant_cnt;
  logic [15:0]   conflict_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [2**AW];

  sp_ram_rr_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
  sp_ram_rr_arbiter_if #(.AW(AW), .DW(DW)) b_if ();

  sp_ram_rr_arbiter #(
    .MEM_WIDTH  (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a_if),
    .b         (b_if),
    .rsp_rdata (rsp_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
`ifdef SP_RAM_ARB_PERF_CNT_EN
    ,
    .cnt_clr      (cnt_clr),
    .a_grant_cnt  (a_grant_cnt),
    .b_grant_cnt  (b_grant_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic v, input logic we,
                       input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    a_if.valid = v;
    a_if.we    = we;
    a_if.addr  = ad;
    a_if.wdata = wd;
  endtask

  task automatic drv_b(input logic v, input logic we,
                       input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    b_if.valid = v;
    b_if.we    = we;
    b_if.addr  = ad;
    b_if.wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = {16'h5A5A, i[7:0]};
    ram_dout = '0;
    rst_n = 1'b0;
`ifdef SP_RAM_ARB_PERF_CNT_EN
    cnt_clr = 1'b0;
`endif
    drv_a(1'b1, 1'b1, 8'h10, 24'hABCDEF);
    drv_b(1'b0, 1'b0, 8'h00, 24'h0);

    // reset: grant visible, write blocked
    #2;
    chk("rst_a_ready", a_if.ready, 1);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_a_rsp", a_if.rsp_valid, 0);
    chk("rst_b_rsp", b_if.rsp_valid, 0);
    tick();
    chk("rst_a_rsp_post", a_if.rsp_valid, 0);
    chk("rst_mem_kept", mem[8'h10], 24'h5A5A10);

    // release, idle
    @(negedge clk);
    rst_n = 1'b1;
    drv_a(1'b0, 1'b0, 8'h00, 24'h0);
    #1;
    chk("idle_a_ready", a_if.ready, 0);
    chk("idle_b_ready", b_if.ready, 0);
    chk("idle_ram_we", ram_we, 0);
    chk("idle_ram_addr", ram_addr, 0);
    chk("idle_ram_din", ram_din, 0);
    tick();
    chk("idle_a_rsp", a_if.rsp_valid, 0);
    chk("idle_b_rsp", b_if.rsp_valid, 0);

    // A write 0x10
    @(negedge clk);
    drv_a(1'b1, 1'b1, 8'h10, 24'hABCDEF);
    #1;
    chk("wr_a_ready", a_if.ready, 1);
    chk("wr_b_ready", b_if.ready, 0);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 32'h10);
    chk("wr_ram_din", ram_din, 32'hABCDEF);
    tick();
    chk("wr_a_rsp", a_if.rsp_valid, 1);
    chk("wr_b_rsp", b_if.rsp_valid, 0);
    chk("wr_old_data", rsp_rdata, 32'h5A5A10);

    // A read 0x10
    @(negedge clk);
    drv_a(1'b1, 1'b0, 8'h10, 24'h0);
    #1;
    chk("rd_a_ready", a_if.ready, 1);
    chk("rd_ram_we", ram_we, 0);
    tick();
    chk("rd_a_rsp", a_if.rsp_valid, 1);
    chk("rd_data", rsp_rdata, 32'hABCDEF);

    // contention straight out of reset
    @(negedge clk);
    drv_a(1'b0, 1'b0, 8'h00, 24'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drv_a(1'b1, 1'b0, 8'h01, 24'h0);
    drv_b(1'b1, 1'b0, 8'h02, 24'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ct_a_ready", a_if.ready, (i % 2 == 0) ? 1 : 0);
      chk("ct_b_ready", b_if.ready, (i % 2 == 0) ? 0 : 1);
      tick();
      chk("ct_a_rsp", a_if.rsp_valid, (i % 2 == 0) ? 1 : 0);
      chk("ct_b_rsp", b_if.rsp_valid, (i % 2 == 0) ? 0 : 1);
      chk("ct_data", rsp_rdata,
          (i % 2 == 0) ? 32'h5A5A01 : 32'h5A5A02);
      @(negedge clk);
    end

    // write-then-read hazard on 0x20
    drv_a(1'b1, 1'b1, 8'h20, 24'h000055);
    drv_b(1'b1, 1'b0, 8'h20, 24'h0);
    #1;
    chk("hz_a_ready", a_if.ready, 1);
    chk("hz_b_ready", b_if.ready, 0);
    chk("hz_ram_we", ram_we, 1);
    tick();
    chk("hz_a_rsp", a_if.rsp_valid, 1);
    chk("hz_a_old", rsp_rdata, 32'h5A5A20);
    @(negedge clk);
    drv_a(1'b0, 1'b0, 8'h00, 24'h0);
    #1;
    chk("hz_b_ready2", b_if.ready, 1);
    chk("hz_ram_we2", ram_we, 0);
    chk("hz_ram_addr2", ram_addr, 32'h20);
    tick();
    chk("hz_b_rsp", b_if.rsp_valid, 1);
    chk("hz_a_rsp2", a_if.rsp_valid, 0);
    chk("hz_b_new", rsp_rdata, 32'h000055);

    // reset right after a grant drops the response
    @(negedge clk);
    drv_b(1'b0, 1'b0, 8'h00, 24'h0);
    drv_a(1'b1, 1'b0, 8'h10, 24'h0);
    #1;
    chk("mr_a_ready", a_if.ready, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_a_rsp", a_if.rsp_valid, 0);
    chk("mr_b_rsp", b_if.rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drv_a(1'b1, 1'b0, 8'h01, 24'h0);
    drv_b(1'b1, 1'b0, 8'h02, 24'h0);
    #1;
    chk("mr_ptr_a", a_if.ready, 1);
    chk("mr_ptr_b", b_if.ready, 0);
    tick();
    chk("mr_a_rsp2", a_if.rsp_valid, 1);
    chk("mr_data", rsp_rdata, 32'h5A5A01);

`ifdef SP_RAM_ARB_PERF_CNT_EN
    @(negedge clk);
    drv_a(1'b0, 1'b0, 8'h00, 24'h0);
    drv_b(1'b0, 1'b0, 8'h00, 24'h0);
    cnt_clr = 1'b1;
    tick();
    @(negedge clk);
    cnt_clr = 1'b0;
    drv_a(1'b1, 1'b0, 8'h01, 24'h0);
    drv_b(1'b1, 1'b0, 8'h02, 24'h0);
    repeat (10) @(negedge clk);
    drv_a(1'b0, 1'b0, 8'h00, 24'h0);
    drv_b(1'b0, 1'b0, 8'h00, 24'h0);
    #1;
    chk("pc_a_cnt", a_grant_cnt, 5);
    chk("pc_b_cnt", b_grant_cnt, 5);
    chk("pc_conflict", conflict_cnt, 10);
    @(negedge clk);
    cnt_clr = 1'b1;
    drv_a(1'b1, 1'b0, 8'h01, 24'h0);
    drv_b(1'b1, 1'b0, 8'h02, 24'h0);
    tick();
    chk("pc_clr_a", a_grant_cnt, 0);
    chk("pc_clr_b", b_grant_cnt, 0);
    chk("pc_clr_c", conflict_cnt, 0);
    @(negedge clk);
    cnt_clr = 1'b0;
    drv_b(1'b0, 1'b0, 8'h00, 24'h0);
    force dut.a_cnt_q = 16'hFFFF;
    #1;
    release dut.a_cnt_q;
    tick();
    chk("pc_sat", a_grant_cnt, 32'hFFFF);
    @(negedge clk);
    drv_a(1'b0, 1'b0, 8'h00, 24'h0);
`endif

    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
